// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: per-stage allow_in/ready/kill strobes, hazard
// resolution (load-use, MDU, memory freeze, mispredict, trap) and stall/flush stats.
module pipe_hazard_ctrl #(
    parameter int MDU_LAT   = 4,
    parameter int CNT_WIDTH = 32,
    parameter int PC_WIDTH  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic [4:0]           D_rs1_addr_i,
    input  logic [4:0]           D_rs2_addr_i,
    input  logic                 D_use_rs1_i,
    input  logic                 D_use_rs2_i,
    input  logic                 E_valid_i,
    input  logic                 E_load_i,
    input  logic                 E_need_dstE_i,
    input  logic [4:0]           E_dstE_i,
    input  logic                 E_mdu_i,
    input  logic                 E_mispredict_i,
    input  logic [PC_WIDTH-1:0]  E_redirect_pc_i,
    input  logic                 E_ecall_i,
    input  logic                 E_mret_i,
    input  logic [PC_WIDTH-1:0]  mtvec_i,
    input  logic [PC_WIDTH-1:0]  mepc_i,
    input  logic                 M_mem_busy_i,
    output logic                 fetch_allow_in_o,
    output logic                 decode_allow_in_o,
    output logic                 execute_allow_in_o,
    output logic                 memory_allow_in_o,
    output logic                 decode_ready_o,
    output logic                 fetch_control_o,
    output logic                 decode_control_o,
    output logic                 redirect_valid_o,
    output logic [PC_WIDTH-1:0]  redirect_pc_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    localparam int MCW = (MDU_LAT > 2) ? $clog2(MDU_LAT - 1) : 1;

    typedef enum logic [1:0] {RUN, MDU_WAIT, TRAP_DRAIN, TRAP_REDIR} state_t;

    state_t                state_reg;
    logic [MCW-1:0]        mdu_cnt_reg;
    logic [PC_WIDTH-1:0]   trap_pc_reg;
    logic [CNT_WIDTH-1:0]  stall_cnt_reg;
    logic [CNT_WIDTH-1:0]  flush_cnt_reg;

    logic freeze;
    logic trap_req;
    logic mispred_req;
    logic mdu_req;
    logic load_use;

    assign freeze      = M_mem_busy_i;
    assign trap_req    = E_valid_i & (E_ecall_i | E_mret_i);
    assign mispred_req = E_valid_i & E_mispredict_i;
    assign mdu_req     = E_valid_i & E_mdu_i;
    // x0 is hardwired zero, so a load targeting it can never create a dependency
    assign load_use    = E_valid_i & E_load_i & E_need_dstE_i & (E_dstE_i != 5'd0) &
                         ((D_use_rs1_i & (D_rs1_addr_i == E_dstE_i)) |
                          (D_use_rs2_i & (D_rs2_addr_i == E_dstE_i)));

    always_comb begin
        fetch_allow_in_o   = 1'b1;
        decode_allow_in_o  = 1'b1;
        execute_allow_in_o = 1'b1;
        memory_allow_in_o  = 1'b1;
        decode_ready_o     = 1'b1;
        fetch_control_o    = 1'b1;
        decode_control_o   = 1'b1;
        redirect_valid_o   = 1'b0;
        redirect_pc_o      = '0;
        case (state_reg)
            RUN: begin
                if (freeze) begin
                    fetch_allow_in_o   = 1'b0;
                    decode_allow_in_o  = 1'b0;
                    execute_allow_in_o = 1'b0;
                    memory_allow_in_o  = 1'b0;
                end else if (trap_req) begin
                    fetch_control_o  = 1'b0;
                    decode_control_o = 1'b0;
                end else if (mispred_req) begin
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = E_redirect_pc_i;
                    fetch_control_o  = 1'b0;
                    decode_control_o = 1'b0;
                end else if (mdu_req) begin
                    fetch_allow_in_o   = 1'b0;
                    decode_allow_in_o  = 1'b0;
                    execute_allow_in_o = 1'b0;
                end else if (load_use) begin
                    fetch_allow_in_o  = 1'b0;
                    decode_allow_in_o = 1'b0;
                    decode_ready_o    = 1'b0;
                end
            end
            MDU_WAIT: begin
                fetch_allow_in_o  = 1'b0;
                decode_allow_in_o = 1'b0;
                if (freeze) begin
                    execute_allow_in_o = 1'b0;
                    memory_allow_in_o  = 1'b0;
                end else begin
                    execute_allow_in_o = (mdu_cnt_reg == '0);
                end
            end
            TRAP_DRAIN: begin
                fetch_control_o  = 1'b0;
                decode_control_o = 1'b0;
            end
            TRAP_REDIR: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = trap_pc_reg;
                fetch_control_o  = 1'b0;
                decode_control_o = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            mdu_cnt_reg   <= '0;
            trap_pc_reg   <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (!fetch_allow_in_o && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (redirect_valid_o && (flush_cnt_reg != '1))
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            case (state_reg)
                RUN: begin
                    if (!freeze) begin
                        if (trap_req) begin
                            trap_pc_reg <= E_ecall_i ? mtvec_i : mepc_i;
                            state_reg   <= TRAP_DRAIN;
                        end else if (!mispred_req && mdu_req) begin
                            // entry cycle counts as the first of MDU_LAT occupancy cycles
                            mdu_cnt_reg <= MCW'(MDU_LAT - 2);
                            state_reg   <= MDU_WAIT;
                        end
                    end
                end
                MDU_WAIT: begin
                    if (!freeze) begin
                        if (mdu_cnt_reg == '0)
                            state_reg <= RUN;
                        else
                            mdu_cnt_reg <= mdu_cnt_reg - 1'b1;
                    end
                end
                TRAP_DRAIN: begin
                    if (!freeze)
                        state_reg <= TRAP_REDIR;
                end
                TRAP_REDIR: state_reg <= RUN;
                default:    state_reg <= RUN;
            endcase
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
    assign flush_cnt_o = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: each step queues its expected strobes and
// counters, then pops and checks them at the falling edge of that cycle.
module tb_pipe_hazard_ctrl;

    localparam int CW = 4;
    localparam int PW = 32;

    // expected strobe vector: {fa, da, ea, ma, dr, fc, dc, rv}
    localparam logic [7:0] C_IDLE   = 8'hFE;
    localparam logic [7:0] C_FREEZE = 8'h0E;
    localparam logic [7:0] C_LDUSE  = 8'h36;
    localparam logic [7:0] C_MDU    = 8'h1E;
    localparam logic [7:0] C_MDUEND = 8'h3E;
    localparam logic [7:0] C_REDIR  = 8'hF9;
    localparam logic [7:0] C_KILL   = 8'hF8;

    typedef struct {
        string            tag;
        logic [7:0]       ctl;
        logic [PW-1:0]    pc;
        logic [CW-1:0]    stall;
        logic [CW-1:0]    flush;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] D_rs1_addr_i = '0, D_rs2_addr_i = '0, E_dstE_i = '0;
    logic D_use_rs1_i = 0, D_use_rs2_i = 0, E_valid_i = 0, E_load_i = 0, E_need_dstE_i = 0;
    logic E_mdu_i = 0, E_mispredict_i = 0, E_ecall_i = 0, E_mret_i = 0, M_mem_busy_i = 0;
    logic [PW-1:0] E_redirect_pc_i = '0, mtvec_i = '0, mepc_i = '0;
    logic fetch_allow_in_o, decode_allow_in_o, execute_allow_in_o, memory_allow_in_o;
    logic decode_ready_o, fetch_control_o, decode_control_o, redirect_valid_o;
    logic [PW-1:0] redirect_pc_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    int checks = 0;
    int failures = 0;
    int m_stall = 0;
    int m_flush = 0;
    exp_t sb[$];

    pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_WIDTH(CW), .PC_WIDTH(PW)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .D_rs1_addr_i(D_rs1_addr_i), .D_rs2_addr_i(D_rs2_addr_i),
        .D_use_rs1_i(D_use_rs1_i), .D_use_rs2_i(D_use_rs2_i),
        .E_valid_i(E_valid_i), .E_load_i(E_load_i), .E_need_dstE_i(E_need_dstE_i),
        .E_dstE_i(E_dstE_i), .E_mdu_i(E_mdu_i), .E_mispredict_i(E_mispredict_i),
        .E_redirect_pc_i(E_redirect_pc_i), .E_ecall_i(E_ecall_i), .E_mret_i(E_mret_i),
        .mtvec_i(mtvec_i), .mepc_i(mepc_i), .M_mem_busy_i(M_mem_busy_i),
        .fetch_allow_in_o(fetch_allow_in_o), .decode_allow_in_o(decode_allow_in_o),
        .execute_allow_in_o(execute_allow_in_o), .memory_allow_in_o(memory_allow_in_o),
        .decode_ready_o(decode_ready_o), .fetch_control_o(fetch_control_o),
        .decode_control_o(decode_control_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic clear_e();
        E_valid_i = 0; E_load_i = 0; E_need_dstE_i = 0; E_dstE_i = '0; E_mdu_i = 0;
        E_mispredict_i = 0; E_ecall_i = 0; E_mret_i = 0;
        D_use_rs1_i = 0; D_use_rs2_i = 0; D_rs1_addr_i = '0; D_rs2_addr_i = '0;
    endtask

    // one cycle: queue expectation, check at negedge, advance model, move past posedge
    task automatic step(input string tag, input logic [7:0] ctl, input logic [PW-1:0] pc);
        exp_t e;
        logic [7:0] obs;
        e.tag = tag; e.ctl = ctl; e.pc = pc;
        e.stall = CW'(m_stall); e.flush = CW'(m_flush);
        sb.push_back(e);
        @(negedge clk_i);
        e = sb.pop_front();
        obs = {fetch_allow_in_o, decode_allow_in_o, execute_allow_in_o, memory_allow_in_o,
               decode_ready_o, fetch_control_o, decode_control_o, redirect_valid_o};
        checks++;
        assert (obs === e.ctl) else begin
            failures++;
            $error("FAIL %s strobes observed=%h expected=%h", e.tag, obs, e.ctl);
        end
        checks++;
        assert (redirect_pc_o === e.pc) else begin
            failures++;
            $error("FAIL %s redirect_pc observed=%h expected=%h", e.tag, redirect_pc_o, e.pc);
        end
        checks++;
        assert (stall_cnt_o === e.stall && flush_cnt_o === e.flush) else begin
            failures++;
            $error("FAIL %s counters observed=%0d/%0d expected=%0d/%0d",
                   e.tag, stall_cnt_o, flush_cnt_o, e.stall, e.flush);
        end
        if (rst_n) begin
            if (!e.ctl[7] && m_stall < 15) m_stall++;
            if (e.ctl[0] && m_flush < 15) m_flush++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        clear_e();
        E_valid_i = 1; E_load_i = 1; E_need_dstE_i = 1; E_dstE_i = rd;
        D_use_rs2_i = 1; D_rs2_addr_i = rd;
    endtask

    initial begin
        clear_e();
        step("reset", C_IDLE, '0);
        rst_n = 1;
        step("idle", C_IDLE, '0);

        set_load_use(5'd5);
        step("ldu_x5", C_LDUSE, '0);
        clear_e();
        step("ldu_after", C_IDLE, '0);
        set_load_use(5'd0);
        step("ldu_x0", C_IDLE, '0);
        clear_e();
        E_valid_i = 1; E_load_i = 1; E_need_dstE_i = 1; E_dstE_i = 5'd7; D_rs1_addr_i = 5'd7;
        step("ldu_rs1_unused", C_IDLE, '0);
        D_use_rs1_i = 1;
        step("ldu_rs1", C_LDUSE, '0);

        clear_e();
        E_valid_i = 1; E_mdu_i = 1;
        step("mdu_t0", C_MDU, '0);
        step("mdu_t1", C_MDU, '0);
        step("mdu_t2", C_MDU, '0);
        step("mdu_t3", C_MDUEND, '0);
        clear_e();
        step("mdu_done", C_IDLE, '0);

        E_valid_i = 1; E_mispredict_i = 1; E_redirect_pc_i = 32'h8000_0040;
        step("mispred", C_REDIR, 32'h8000_0040);
        clear_e();
        step("mispred_after", C_IDLE, '0);
        E_valid_i = 1; E_mispredict_i = 1; M_mem_busy_i = 1;
        step("mispred_frz0", C_FREEZE, '0);
        step("mispred_frz1", C_FREEZE, '0);
        M_mem_busy_i = 0;
        step("mispred_unfrz", C_REDIR, 32'h8000_0040);
        clear_e();
        step("mispred2_after", C_IDLE, '0);

        E_valid_i = 1; E_ecall_i = 1; mtvec_i = 32'h8000_0100;
        step("ecall_entry", C_KILL, '0);
        clear_e();
        mtvec_i = '0;
        M_mem_busy_i = 1;
        step("ecall_drain0", C_KILL, '0);
        step("ecall_drain1", C_KILL, '0);
        step("ecall_drain2", C_KILL, '0);
        M_mem_busy_i = 0;
        step("ecall_drain3", C_KILL, '0);
        step("ecall_redir", C_REDIR, 32'h8000_0100);
        step("ecall_done", C_IDLE, '0);

        E_valid_i = 1; E_mret_i = 1; mepc_i = 32'h8000_0024;
        step("mret_entry", C_KILL, '0);
        clear_e();
        step("mret_drain", C_KILL, '0);
        step("mret_redir", C_REDIR, 32'h8000_0024);
        step("mret_done", C_IDLE, '0);

        E_valid_i = 1; E_ecall_i = 1; E_mret_i = 1; E_mispredict_i = 1;
        E_redirect_pc_i = 32'h0000_1234; mtvec_i = 32'h8000_0100;
        step("ecall_misp", C_KILL, '0);
        clear_e();
        step("ecall_misp_drain", C_KILL, '0);
        step("ecall_misp_redir", C_REDIR, 32'h8000_0100);
        step("ecall_misp_done", C_IDLE, '0);

        E_valid_i = 1; E_mdu_i = 1;
        step("mdu_rst_t0", C_MDU, '0);
        step("mdu_rst_t1", C_MDU, '0);
        clear_e();
        rst_n = 0;
        m_stall = 0; m_flush = 0;
        step("mdu_rst", C_IDLE, '0);
        rst_n = 1;
        step("post_rst", C_IDLE, '0);

        for (int i = 0; i < 20; i++) begin
            set_load_use(5'(i % 31 + 1));
            step($sformatf("sat_%0d", i), C_LDUSE, '0);
        end
        clear_e();
        step("sat_hold", C_IDLE, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
